// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants.
package mips_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} fetch_state_t;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: next-PC select with word-aligned redirect and modulo +4 advance.
module fetch_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc_next
);
    assign pc_next = redirect ? (redirect_pc & ~32'h3) : advance ? pc + WORD_BYTES : pc;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, fetches words over req/ack and presents them to the decoder.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    fetch_state_t state, state_next;
    logic [31:0] pc, pc_next, req_addr, instr_reg;
    logic advance;

    assign advance = state == HOLD && instr_ready && !redirect;

    fetch_pc_sel u_pc_sel (
        .pc          (pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .advance     (advance),
        .pc_next     (pc_next)
    );

    // A redirected request that is still unacked is drained from req_addr so the bus address stays put.
    always_comb begin
        state_next  = state == IDLE  ? FETCH :
                      state == FETCH ? (imem_ack && !redirect ? HOLD : !imem_ack && redirect ? DRAIN : FETCH) :
                      state == DRAIN ? (imem_ack ? FETCH : DRAIN) :
                      (redirect || instr_ready ? FETCH : HOLD);
        imem_req    = state == FETCH || state == DRAIN;
        imem_addr   = state == DRAIN ? req_addr : pc;
        instr_valid = state == HOLD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            instr_reg <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == FETCH) req_addr <= pc;
            if (state == FETCH && imem_ack && !redirect) instr_reg <= imem_rdata;
        end
    end

    assign instruction = instr_reg;
    assign pc_out      = pc;
    assign pc_plus4    = pc + WORD_BYTES;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench with a variable-latency memory model and a delivery scoreboard.
module tb_instr_fetch;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        imem_req, imem_ack = 0, instr_valid, instr_ready = 0, redirect = 0;
    logic [31:0] imem_addr, imem_rdata = 0, instruction, pc_out, pc_plus4, redirect_pc = 0;
    int checks = 0, failures = 0, lat = 0;
    logic [31:0] exp_pc[$], exp_ins[$];

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instruction(instruction), .pc_out(pc_out),
        .pc_plus4(pc_plus4), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h2408_0005 + (a - 32'h0000_3000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] a);
        exp_pc.push_back(a);
        exp_ins.push_back(word(a));
    endtask

    task automatic consume;
        logic [31:0] p, w;
        int n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        chk("valid", {31'b0, instr_valid}, 32'd1);
        if (exp_pc.size() == 0) begin exp_pc.push_back('x); exp_ins.push_back('x); end
        p = exp_pc.pop_front();
        w = exp_ins.pop_front();
        chk("pc_out", pc_out, p);
        chk("instruction", instruction, w);
        chk("pc_plus4", pc_plus4, p + 32'd4);
        chk("hold_no_req", {31'b0, imem_req}, 32'd0);
    endtask

    task automatic fetch_at(input string tag, input logic [31:0] a);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, a);
        chk({tag, "_novalid"}, {31'b0, instr_valid}, 32'd0);
    endtask

    // Memory: acks after lat extra wait cycles and checks the address is held while pending.
    initial begin
        int cnt = 0;
        logic pend = 0;
        logic [31:0] held = 0;
        forever begin
            @(negedge clk);
            imem_ack = 0;
            if (!rst_n || !imem_req) begin
                cnt = 0;
                pend = 0;
            end else begin
                if (pend) chk("addr_stable", imem_addr, held);
                if (cnt == lat) begin
                    imem_ack = 1;
                    imem_rdata = word(imem_addr);
                    cnt = 0;
                    pend = 0;
                end else begin
                    cnt++;
                    pend = 1;
                    held = imem_addr;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hold_ins;
        tick(); tick();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pc", pc_out, 32'h0000_3000);
        chk("rst_pc4", pc_plus4, 32'h0000_3004);
        chk("rst_ins", instruction, 32'd0);
        rst_n = 1; instr_ready = 1;
        tick();
        fetch_at("f3000", 32'h0000_3000);
        expect_word(32'h0000_3000);
        tick();
        consume();
        chk("first_word", instruction, 32'h2408_0005);
        tick();
        fetch_at("f3004", 32'h0000_3004);
        expect_word(32'h0000_3004);
        instr_ready = 0;
        tick();
        consume();
        hold_ins = instruction;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_valid", {31'b0, instr_valid}, 32'd1);
            chk("bp_pc", pc_out, 32'h0000_3004);
            chk("bp_ins", instruction, hold_ins);
            chk("bp_noreq", {31'b0, imem_req}, 32'd0);
        end
        instr_ready = 1; lat = 3;
        tick();
        fetch_at("f3008", 32'h0000_3008);
        redirect = 1; redirect_pc = 32'h0000_3100;
        tick();
        redirect = 0;
        for (int i = 0; i < 3; i++) begin
            fetch_at("drain", 32'h0000_3008);
            chk("drain_pc", pc_out, 32'h0000_3100);
            tick();
        end
        fetch_at("f3100", 32'h0000_3100);
        expect_word(32'h0000_3100);
        lat = 0;
        tick();
        consume();
        tick();
        fetch_at("f3104", 32'h0000_3104);
        redirect = 1; redirect_pc = 32'h0000_3203;
        tick();
        redirect = 0;
        fetch_at("f3200", 32'h0000_3200);
        tick();
        chk("hold3200_valid", {31'b0, instr_valid}, 32'd1);
        chk("hold3200_pc", pc_out, 32'h0000_3200);
        redirect = 1; redirect_pc = 32'h0000_3403;
        tick();
        redirect = 0;
        fetch_at("f3400", 32'h0000_3400);
        expect_word(32'h0000_3400);
        tick();
        consume();
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 0;
        fetch_at("fwrap", 32'hFFFF_FFFC);
        expect_word(32'hFFFF_FFFC);
        tick();
        consume();
        tick();
        fetch_at("f0000", 32'h0000_0000);
        lat = 5; redirect = 1; redirect_pc = 32'h0000_3500;
        tick();
        redirect = 0;
        fetch_at("drain0", 32'h0000_0000);
        rst_n = 0;
        tick();
        chk("mrst_req", {31'b0, imem_req}, 32'd0);
        chk("mrst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mrst_pc", pc_out, 32'h0000_3000);
        rst_n = 1; lat = 0;
        tick();
        fetch_at("restart", 32'h0000_3000);
        expect_word(32'h0000_3000);
        tick();
        consume();
        chk("sb_drained", exp_pc.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction field decoder.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake with variable latency.
- Holds the fetched 32-bit instruction with a valid/ready handshake for the decoder.
- Accepts PC redirects (branch/jump/jr targets) from later stages, discarding wrong-path or in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset; the first fetch address.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- imem_req  out  1  instruction memory read request
- imem_addr  out  32  byte address of request; word-aligned
- imem_ack  in  1  one-cycle pulse; imem_rdata valid same cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instruction/pc_out valid to decoder
- instr_ready  in  1  decoder accepts this cycle
- instruction  out  32  fetched instruction word
- pc_out  out  32  address of the presented instruction
- pc_plus4  out  32  pc_out + 4, for link and branch base
- redirect  in  1  load a new PC; flush current fetch
- redirect_pc  in  32  redirect target

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n low at an edge) produces:
  - pc = RESET_PC, req_addr = RESET_PC, state IDLE, instruction = 0
  - imem_req = 0, instr_valid = 0, pc_out = RESET_PC, pc_plus4 = RESET_PC+4
- Reset mid-transaction abandons any outstanding request. The memory must drop a pending ack when rst_n is low.
- All outputs are driven from registers (state, pc, req_addr, instr_reg). There are no combinational input-to-output paths.
- States:
  - IDLE: imem_req = 0. Moves to FETCH unconditionally next cycle, so the first request appears one cycle after reset release.
  - FETCH: imem_req = 1, imem_addr = pc; req_addr <= pc.
    - imem_ack & !redirect: instr_reg <= imem_rdata, go HOLD.
    - imem_ack & redirect: discard data, pc <= target, stay FETCH. A new request with the new address starts next cycle.
    - !imem_ack & redirect: pc <= target, go DRAIN.
  - DRAIN: imem_req = 1, imem_addr = req_addr. The outstanding request is held unchanged until acked.
    - imem_ack: discard data, go FETCH.
    - redirect: pc <= target, independent of ack; the latest redirect wins.
  - HOLD: instr_valid = 1, instruction = instr_reg, pc_out = pc.
    - redirect: pc <= target, go FETCH. Any same-cycle valid&ready is void; the decoder flushes.
    - instr_ready & !redirect: pc <= pc+4, go FETCH.
    - Otherwise: hold all outputs stable.
- Memory protocol:
  - imem_addr must not change while imem_req is high and unacked.
  - ack sampled at the edge; ack in the first request cycle (zero wait) is legal.
  - An ack while imem_req = 0 is ignored.
- instr_valid is 0 in IDLE, FETCH and DRAIN. pc_out/pc_plus4 track pc in every state.
- Redirect target has bits [1:0] forced to 0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Throughput: at most one instruction per 2 cycles (FETCH with ack, then HOLD with ready).

Decomposition:
- Shared package (mips_pkg):
  - fetch state enum (IDLE, FETCH, DRAIN, HOLD)
  - DEFAULT_RESET_PC = 32'h0000_3000
  - WORD_BYTES = 4
- One combinational sub-module, fetch_pc_sel:
  - Inputs: pc, redirect, redirect_pc, advance.
  - Outputs: next pc, with alignment masking and +4 wrap.
- The FSM and registers stay in instr_fetch.

Test Plan:
- Reset then release; memory ack on the first req cycle with rdata 32'h2408_0005; instr_ready=1. Expect:
  - imem_addr = 32'h0000_3000, then 32'h0000_3004
  - instr_valid pulses every 2nd cycle
  - pc_out 3000, 3004…; pc_plus4 = pc_out+4
- Backpressure: instr_ready=0 for 5 cycles in HOLD. Expect instruction, pc_out and instr_valid stable, and imem_req=0 throughout. Ready=1 then advances pc to +4.
- Redirect during a 3-cycle-latency fetch at pc=32'h3008 with redirect_pc=32'h0000_3100. Expect:
  - imem_addr stays 3008 until ack; that data is discarded
  - next request at 3100; first valid has pc_out=3100
- Redirect coincident with ack, and redirect in HOLD with instr_ready=1; target 32'h0000_3203. Expect:
  - no instr_valid for the old word
  - next imem_addr = 32'h0000_3200
- Wrap: redirect to 32'hFFFF_FFFC, accept one instruction. Expect next imem_addr = 32'h0000_0000.
- rst_n low while DRAIN is outstanding. Expect imem_req=0 and instr_valid=0 at the next edge, then restart fetch at RESET_PC.
